// File: rtl/rob_commit_unit_pkg.sv
// rob_commit_unit_pkg
// Shared sizing constants and tag/register types for the reorder buffer and
// commit stage. These are the same constants the rename block uses.
package rob_commit_unit_pkg;

  localparam int RRF_NUM = 64;  // ROB/RRF entries, power of two
  localparam int RRF_SEL = 6;   // log2(RRF_NUM)
  localparam int REG_SEL = 5;   // architectural register index width

  typedef logic [RRF_SEL-1:0] rrf_tag_t;
  typedef logic [REG_SEL-1:0] reg_num_t;

  // Tag arithmetic wraps modulo RRF_NUM because RRF_NUM == 2**RRF_SEL.
  function automatic rrf_tag_t tag_inc(input rrf_tag_t t);
    return t + rrf_tag_t'(1);
  endfunction

endpackage

// File: rtl/rob_commit_unit_entry_array.sv
// rob_commit_unit_entry_array (module rob_entry_array)
// Per-entry ROB storage: valid, finished, dst_en, dst_num.
// Ports:
//   clk, reset           clock, async active-high reset (clears valid/finished)
//   wr1_*, wr2_*         dispatch write ports (set valid, clear finished)
//   fin1_*, fin2_*       finish-set ports (ignored for entries not valid)
//   clr_en, clr_tag      commit clear port
//   rd_tag, rd_*         combinational read of one entry (the commit pointer)
module rob_entry_array
  import rob_commit_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr1_en,
  input  logic [RRF_SEL-1:0] wr1_tag,
  input  logic               wr1_dst_en,
  input  logic [REG_SEL-1:0] wr1_dst_num,
  input  logic               wr2_en,
  input  logic [RRF_SEL-1:0] wr2_tag,
  input  logic               wr2_dst_en,
  input  logic [REG_SEL-1:0] wr2_dst_num,
  input  logic               fin1_en,
  input  logic [RRF_SEL-1:0] fin1_tag,
  input  logic               fin2_en,
  input  logic [RRF_SEL-1:0] fin2_tag,
  input  logic               clr_en,
  input  logic [RRF_SEL-1:0] clr_tag,
  input  logic [RRF_SEL-1:0] rd_tag,
  output logic               rd_valid,
  output logic               rd_finished,
  output logic               rd_dst_en,
  output logic [REG_SEL-1:0] rd_dst_num
);

  logic [RRF_NUM-1:0] valid;
  logic [RRF_NUM-1:0] finished;
  logic [RRF_NUM-1:0] dst_en;
  reg_num_t           dst_num [RRF_NUM];

  // Later assignments win: finish < commit clear < dispatch. A commit on an
  // entry being finished simply clears it; an (illegal) dispatch into the
  // retiring entry keeps the new instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid    <= '0;
      finished <= '0;
      dst_en   <= '0;
      dst_num  <= '{default: '0};
    end else begin
      if (fin1_en && valid[fin1_tag]) finished[fin1_tag] <= 1'b1;
      if (fin2_en && valid[fin2_tag]) finished[fin2_tag] <= 1'b1;
      if (clr_en) begin
        valid[clr_tag]    <= 1'b0;
        finished[clr_tag] <= 1'b0;
      end
      if (wr1_en) begin
        valid[wr1_tag]    <= 1'b1;
        finished[wr1_tag] <= 1'b0;
        dst_en[wr1_tag]   <= wr1_dst_en;
        dst_num[wr1_tag]  <= wr1_dst_num;
      end
      if (wr2_en) begin
        valid[wr2_tag]    <= 1'b1;
        finished[wr2_tag] <= 1'b0;
        dst_en[wr2_tag]   <= wr2_dst_en;
        dst_num[wr2_tag]  <= wr2_dst_num;
      end
    end
  end

  assign rd_valid    = valid[rd_tag];
  assign rd_finished = finished[rd_tag];
  assign rd_dst_en   = dst_en[rd_tag];
  assign rd_dst_num  = dst_num[rd_tag];

endmodule

// File: rtl/rob_commit_unit.sv
// rob_commit_unit
// Reorder buffer with in-order, single-wide commit. Dispatched instructions
// are recorded at their RRF tag; finish reports mark them done; the oldest
// entry (comptr) retires once finished.
// Ports:
//   clk, reset                       clock, async active-high reset
//   stall_dp_i, rrfptr_i             dispatch stall and base tag
//   dp1_*/dp2_*                      dispatch slots (slot 2 needs slot 1)
//   fin1_*/fin2_*                    finish reports (ALU, LSU)
//   completed_*_o, com_inst_num_o    retire interface to Arf/Rrf/allocator
//   comptr_o, rob_empty_o            commit pointer and empty flag
module rob_commit_unit
  import rob_commit_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_dp_i,
  input  logic [RRF_SEL-1:0] rrfptr_i,
  input  logic               dp1_i,
  input  logic               dp1_dst_en_i,
  input  logic [REG_SEL-1:0] dp1_dst_num_i,
  input  logic               dp2_i,
  input  logic               dp2_dst_en_i,
  input  logic [REG_SEL-1:0] dp2_dst_num_i,
  input  logic               fin1_we_i,
  input  logic [RRF_SEL-1:0] fin1_rrftag_i,
  input  logic               fin2_we_i,
  input  logic [RRF_SEL-1:0] fin2_rrftag_i,
  output logic               completed_we_o,
  output logic [REG_SEL-1:0] completed_dst_num_o,
  output logic [RRF_SEL-1:0] completed_dst_rrftag_o,
  output logic [1:0]         com_inst_num_o,
  output logic [RRF_SEL-1:0] comptr_o,
  output logic               rob_empty_o
);

  rrf_tag_t comptr;
  logic     wr1_en, wr2_en;
  logic     head_valid, head_finished, head_dst_en;
  reg_num_t head_dst_num;
  logic     commit;

  assign wr1_en = ~stall_dp_i & dp1_i;
  assign wr2_en = ~stall_dp_i & dp1_i & dp2_i;

  rob_entry_array u_array (
    .clk         (clk),
    .reset       (reset),
    .wr1_en      (wr1_en),
    .wr1_tag     (rrfptr_i),
    .wr1_dst_en  (dp1_dst_en_i),
    .wr1_dst_num (dp1_dst_num_i),
    .wr2_en      (wr2_en),
    .wr2_tag     (tag_inc(rrfptr_i)),
    .wr2_dst_en  (dp2_dst_en_i),
    .wr2_dst_num (dp2_dst_num_i),
    .fin1_en     (fin1_we_i),
    .fin1_tag    (fin1_rrftag_i),
    .fin2_en     (fin2_we_i),
    .fin2_tag    (fin2_rrftag_i),
    .clr_en      (commit),
    .clr_tag     (comptr),
    .rd_tag      (comptr),
    .rd_valid    (head_valid),
    .rd_finished (head_finished),
    .rd_dst_en   (head_dst_en),
    .rd_dst_num  (head_dst_num)
  );

  // Only registered state feeds the commit decision, so a finish report
  // reaches the retire outputs one cycle later at the earliest.
  assign commit = head_valid & head_finished;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       comptr <= '0;
    else if (commit) comptr <= tag_inc(comptr);
  end

  assign completed_we_o         = commit & head_dst_en;
  assign completed_dst_num_o    = head_dst_num;
  assign completed_dst_rrftag_o = comptr;
  assign com_inst_num_o         = {1'b0, commit};
  assign comptr_o               = comptr;
  assign rob_empty_o            = ~head_valid;

endmodule

// File: tb/tb_rob_commit_unit.sv
module tb_rob_commit_unit;
  import rob_commit_unit_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               stall_dp_i;
  logic [RRF_SEL-1:0] rrfptr_i;
  logic               dp1_i, dp1_dst_en_i;
  logic [REG_SEL-1:0] dp1_dst_num_i;
  logic               dp2_i, dp2_dst_en_i;
  logic [REG_SEL-1:0] dp2_dst_num_i;
  logic               fin1_we_i, fin2_we_i;
  logic [RRF_SEL-1:0] fin1_rrftag_i, fin2_rrftag_i;
  logic               completed_we_o;
  logic [REG_SEL-1:0] completed_dst_num_o;
  logic [RRF_SEL-1:0] completed_dst_rrftag_o;
  logic [1:0]         com_inst_num_o;
  logic [RRF_SEL-1:0] comptr_o;
  logic               rob_empty_o;

  int checks = 0;
  int failures = 0;

  rob_commit_unit dut (
    .clk                    (clk),
    .reset                  (reset),
    .stall_dp_i             (stall_dp_i),
    .rrfptr_i               (rrfptr_i),
    .dp1_i                  (dp1_i),
    .dp1_dst_en_i           (dp1_dst_en_i),
    .dp1_dst_num_i          (dp1_dst_num_i),
    .dp2_i                  (dp2_i),
    .dp2_dst_en_i           (dp2_dst_en_i),
    .dp2_dst_num_i          (dp2_dst_num_i),
    .fin1_we_i              (fin1_we_i),
    .fin1_rrftag_i          (fin1_rrftag_i),
    .fin2_we_i              (fin2_we_i),
    .fin2_rrftag_i          (fin2_rrftag_i),
    .completed_we_o         (completed_we_o),
    .completed_dst_num_o    (completed_dst_num_o),
    .completed_dst_rrftag_o (completed_dst_rrftag_o),
    .com_inst_num_o         (com_inst_num_o),
    .comptr_o               (comptr_o),
    .rob_empty_o            (rob_empty_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    stall_dp_i = 0; rrfptr_i = '0;
    dp1_i = 0; dp1_dst_en_i = 0; dp1_dst_num_i = '0;
    dp2_i = 0; dp2_dst_en_i = 0; dp2_dst_num_i = '0;
    fin1_we_i = 0; fin1_rrftag_i = '0; fin2_we_i = 0; fin2_rrftag_i = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Dispatch one no-destination entry at tag t, finish it, let it retire.
  task automatic retire_filler(input int t);
    rrfptr_i = RRF_SEL'(t); dp1_i = 1; tick(); idle_inputs();
    fin1_we_i = 1; fin1_rrftag_i = RRF_SEL'(t); tick(); idle_inputs();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    checks++; if (rob_empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0d exp=1", rob_empty_o); end
    checks++; if (com_inst_num_o !== 2'd0) begin failures++; $display("FAIL reset_com got=%0d exp=0", com_inst_num_o); end
    checks++; if (completed_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%0d exp=0", completed_we_o); end
    checks++; if (comptr_o !== 6'd0) begin failures++; $display("FAIL reset_comptr got=%0d exp=0", comptr_o); end
    checks++; if (completed_dst_rrftag_o !== 6'd0) begin failures++; $display("FAIL reset_rrftag got=%0d exp=0", completed_dst_rrftag_o); end
    reset = 0;
    tick();
    checks++; if (rob_empty_o !== 1'b1 || com_inst_num_o !== 2'd0) begin failures++; $display("FAIL idle empty/com got=%0d/%0d exp=1/0", rob_empty_o, com_inst_num_o); end
  endtask

  task automatic test_in_order();
    rrfptr_i = 0; dp1_i = 1; dp1_dst_en_i = 1; dp1_dst_num_i = 5'd1;
    tick(); idle_inputs();
    checks++; if (rob_empty_o !== 1'b0) begin failures++; $display("FAIL inorder_valid empty got=%0d exp=0", rob_empty_o); end
    checks++; if (com_inst_num_o !== 2'd0) begin failures++; $display("FAIL inorder_unfinished com got=%0d exp=0", com_inst_num_o); end
    fin1_we_i = 1; fin1_rrftag_i = 0;
    #1;
    checks++; if (com_inst_num_o !== 2'd0) begin failures++; $display("FAIL inorder_same_cycle_fin com got=%0d exp=0", com_inst_num_o); end
    tick(); idle_inputs();
    checks++; if (completed_we_o !== 1'b1) begin failures++; $display("FAIL inorder_we got=%0d exp=1", completed_we_o); end
    checks++; if (completed_dst_num_o !== 5'd1) begin failures++; $display("FAIL inorder_dst_num got=%0d exp=1", completed_dst_num_o); end
    checks++; if (completed_dst_rrftag_o !== 6'd0) begin failures++; $display("FAIL inorder_rrftag got=%0d exp=0", completed_dst_rrftag_o); end
    checks++; if (com_inst_num_o !== 2'd1) begin failures++; $display("FAIL inorder_com got=%0d exp=1", com_inst_num_o); end
    tick();
    checks++; if (comptr_o !== 6'd1) begin failures++; $display("FAIL inorder_comptr got=%0d exp=1", comptr_o); end
    checks++; if (rob_empty_o !== 1'b1) begin failures++; $display("FAIL inorder_empty_after got=%0d exp=1", rob_empty_o); end
    checks++; if (com_inst_num_o !== 2'd0) begin failures++; $display("FAIL inorder_com_after got=%0d exp=0", com_inst_num_o); end
  endtask

  task automatic test_out_of_order();
    for (int t = 1; t < 12; t++) retire_filler(t);
    checks++; if (comptr_o !== 6'd12) begin failures++; $display("FAIL ooo_walk_comptr got=%0d exp=12", comptr_o); end
    rrfptr_i = 6'd12; dp1_i = 1; dp1_dst_en_i = 1; dp1_dst_num_i = 5'd7;
    dp2_i = 1; dp2_dst_en_i = 1; dp2_dst_num_i = 5'd9;
    tick(); idle_inputs();
    fin2_we_i = 1; fin2_rrftag_i = 6'd13;
    tick(); idle_inputs();
    checks++; if (com_inst_num_o !== 2'd0) begin failures++; $display("FAIL ooo_no_commit com got=%0d exp=0", com_inst_num_o); end
    checks++; if (comptr_o !== 6'd12 || rob_empty_o !== 1'b0) begin failures++; $display("FAIL ooo_hold comptr/empty got=%0d/%0d exp=12/0", comptr_o, rob_empty_o); end
    fin1_we_i = 1; fin1_rrftag_i = 6'd12;
    tick(); idle_inputs();
    checks++; if (com_inst_num_o !== 2'd1 || completed_dst_rrftag_o !== 6'd12) begin failures++; $display("FAIL ooo_retire12 com/tag got=%0d/%0d exp=1/12", com_inst_num_o, completed_dst_rrftag_o); end
    checks++; if (completed_dst_num_o !== 5'd7 || completed_we_o !== 1'b1) begin failures++; $display("FAIL ooo_retire12 num/we got=%0d/%0d exp=7/1", completed_dst_num_o, completed_we_o); end
    tick();
    checks++; if (com_inst_num_o !== 2'd1 || completed_dst_rrftag_o !== 6'd13) begin failures++; $display("FAIL ooo_retire13 com/tag got=%0d/%0d exp=1/13", com_inst_num_o, completed_dst_rrftag_o); end
    checks++; if (completed_dst_num_o !== 5'd9) begin failures++; $display("FAIL ooo_retire13 num got=%0d exp=9", completed_dst_num_o); end
    tick();
    checks++; if (comptr_o !== 6'd14 || rob_empty_o !== 1'b1) begin failures++; $display("FAIL ooo_done comptr/empty got=%0d/%0d exp=14/1", comptr_o, rob_empty_o); end
  endtask

  task automatic test_wrap();
    for (int t = 14; t < 63; t++) retire_filler(t);
    checks++; if (comptr_o !== 6'd63) begin failures++; $display("FAIL wrap_walk_comptr got=%0d exp=63", comptr_o); end
    rrfptr_i = 6'd63; dp1_i = 1; dp1_dst_en_i = 1; dp1_dst_num_i = 5'd3;
    dp2_i = 1; dp2_dst_en_i = 1; dp2_dst_num_i = 5'd4;
    tick(); idle_inputs();
    checks++; if (rob_empty_o !== 1'b0) begin failures++; $display("FAIL wrap_valid63 empty got=%0d exp=0", rob_empty_o); end
    // Both ports in one cycle, port 2 reporting the wrapped slot-2 entry.
    fin1_we_i = 1; fin1_rrftag_i = 6'd63; fin2_we_i = 1; fin2_rrftag_i = 6'd0;
    tick(); idle_inputs();
    checks++; if (com_inst_num_o !== 2'd1 || completed_dst_rrftag_o !== 6'd63 || completed_dst_num_o !== 5'd3) begin failures++; $display("FAIL wrap_retire63 com/tag/num got=%0d/%0d/%0d exp=1/63/3", com_inst_num_o, completed_dst_rrftag_o, completed_dst_num_o); end
    tick();
    checks++; if (comptr_o !== 6'd0) begin failures++; $display("FAIL wrap_comptr0 got=%0d exp=0", comptr_o); end
    checks++; if (com_inst_num_o !== 2'd1 || completed_dst_num_o !== 5'd4) begin failures++; $display("FAIL wrap_retire0 com/num got=%0d/%0d exp=1/4", com_inst_num_o, completed_dst_num_o); end
    tick();
    checks++; if (comptr_o !== 6'd1 || rob_empty_o !== 1'b1) begin failures++; $display("FAIL wrap_done comptr/empty got=%0d/%0d exp=1/1", comptr_o, rob_empty_o); end
  endtask

  task automatic test_same_tag_finish();
    rrfptr_i = 6'd1; dp1_i = 1; dp1_dst_en_i = 1; dp1_dst_num_i = 5'd17;
    tick(); idle_inputs();
    fin1_we_i = 1; fin1_rrftag_i = 6'd1; fin2_we_i = 1; fin2_rrftag_i = 6'd1;
    tick(); idle_inputs();
    checks++; if (com_inst_num_o !== 2'd1 || completed_dst_num_o !== 5'd17) begin failures++; $display("FAIL sametag com/num got=%0d/%0d exp=1/17", com_inst_num_o, completed_dst_num_o); end
    tick();
    checks++; if (comptr_o !== 6'd2) begin failures++; $display("FAIL sametag_comptr got=%0d exp=2", comptr_o); end
  endtask

  task automatic test_stall_gating();
    stall_dp_i = 1; rrfptr_i = 6'd2; dp1_i = 1; dp1_dst_en_i = 1;
    tick(); idle_inputs();
    checks++; if (rob_empty_o !== 1'b1) begin failures++; $display("FAIL stall_ignored empty got=%0d exp=1", rob_empty_o); end
    rrfptr_i = 6'd1; dp1_i = 0; dp2_i = 1; dp2_dst_en_i = 1;
    tick(); idle_inputs();
    checks++; if (rob_empty_o !== 1'b1) begin failures++; $display("FAIL dp2_alone_ignored empty got=%0d exp=1", rob_empty_o); end
    checks++; if (comptr_o !== 6'd2) begin failures++; $display("FAIL gating_comptr got=%0d exp=2", comptr_o); end
  endtask

  task automatic test_no_dst_and_reset();
    rrfptr_i = 6'd2; dp1_i = 1; dp1_dst_en_i = 0; dp1_dst_num_i = 5'd5;
    tick(); idle_inputs();
    fin1_we_i = 1; fin1_rrftag_i = 6'd2;
    tick(); idle_inputs();
    checks++; if (com_inst_num_o !== 2'd1) begin failures++; $display("FAIL nodst_com got=%0d exp=1", com_inst_num_o); end
    checks++; if (completed_we_o !== 1'b0) begin failures++; $display("FAIL nodst_we got=%0d exp=0", completed_we_o); end
    checks++; if (completed_dst_num_o !== 5'd5) begin failures++; $display("FAIL nodst_num got=%0d exp=5", completed_dst_num_o); end
    tick();
    checks++; if (comptr_o !== 6'd3) begin failures++; $display("FAIL nodst_comptr got=%0d exp=3", comptr_o); end
    rrfptr_i = 6'd3; dp1_i = 1; dp1_dst_en_i = 1; dp1_dst_num_i = 5'd8;
    dp2_i = 1; dp2_dst_en_i = 1; dp2_dst_num_i = 5'd10;
    tick(); idle_inputs();
    rrfptr_i = 6'd5; dp1_i = 1; dp1_dst_en_i = 1; dp1_dst_num_i = 5'd11;
    fin1_we_i = 1; fin1_rrftag_i = 6'd3;
    tick(); idle_inputs();
    checks++; if (rob_empty_o !== 1'b0 || com_inst_num_o !== 2'd1) begin failures++; $display("FAIL midreset_pre empty/com got=%0d/%0d exp=0/1", rob_empty_o, com_inst_num_o); end
    reset = 1;
    #1;
    checks++; if (rob_empty_o !== 1'b1 || comptr_o !== 6'd0) begin failures++; $display("FAIL midreset_async empty/comptr got=%0d/%0d exp=1/0", rob_empty_o, comptr_o); end
    checks++; if (com_inst_num_o !== 2'd0 || completed_we_o !== 1'b0) begin failures++; $display("FAIL midreset_async com/we got=%0d/%0d exp=0/0", com_inst_num_o, completed_we_o); end
    tick();
    reset = 0;
    tick();
    checks++; if (rob_empty_o !== 1'b1 || comptr_o !== 6'd0 || com_inst_num_o !== 2'd0) begin failures++; $display("FAIL postreset empty/comptr/com got=%0d/%0d/%0d exp=1/0/0", rob_empty_o, comptr_o, com_inst_num_o); end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_in_order();
    test_out_of_order();
    test_wrap();
    test_same_tag_finish();
    test_stall_gating();
    test_no_dst_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
